paralelo_serial_tx: RTL
=======================

Name: paralelo_serial_tx

Overview:
- Transmit-side PHY serializer; sits directly upstream of the serial-to-parallel receiver on the serial link.
- Accepts bytes over a valid/ready handshake and shifts them out MSB first, one bit per clk_32f cycle.
- Sends comma 0xBC when no data is offered.
- After reset, sends a burst of sync commas so the far-end receiver can lock and assert its active flag.

Parameters:
- SYNC_COMMAS, 4: number of commas sent after reset before any data is accepted. Minimum 1.
- COMMA_PERIOD, 16: data bytes between forced commas. Used only with PS_TX_PERIODIC_COMMA_EN.

Ports:
- clk_32f  in  1  bit clock; all state on posedge.
- rst_L  in  1  reset; asynchronous, active-low.
- data_in  in  8  byte to transmit.
- valid_in  in  1  data_in valid; held with data_in stable until accepted.
- ready_out  out  1  slot open; transfer occurs on a posedge with valid_in && ready_out.
- data_out  out  1  serial bit, registered.
- active_out  out  1  sync burst complete; data slots available.

Behaviour:
- Reset values (asynchronous, while rst_L=0):
  - bit_cnt=7, shreg=0, sync_cnt=0, state=SYNC.
  - data_out=0, ready_out=0, active_out=0.
- Load edge: any posedge with bit_cnt==7. On it:
  - bit_cnt<=0.
  - data_out<=next_byte[7].
  - shreg<={next_byte[6:0],1'b0}.
- Non-load edge:
  - data_out<=shreg[7], shreg<=shreg<<1, bit_cnt<=bit_cnt+1 (3-bit).
- Each byte therefore occupies exactly 8 consecutive cycles, MSB first.
- Latency: data_in[7] appears on data_out in the cycle immediately after the accepting edge.
- State machine:
  - SYNC: next_byte=0xBC at every load edge; sync_cnt increments.
  - SYNC exit: on the load edge that loads comma number SYNC_COMMAS, state<=ACTIVE and active_out<=1.
  - ACTIVE: at a load edge, next_byte=data_in if valid_in, else 0xBC.
  - ACTIVE is held until reset.
- ready_out = (state==ACTIVE) && (bit_cnt==7), driven from registers.
  - High exactly one cycle in every 8.
  - Never high in SYNC.
- valid_in outside a ready cycle has no effect. The source holds the byte until the next ready cycle.
- First edge after rst_L release is a load edge (comma 1).
  - With SYNC_COMMAS=4, commas load at edges 1, 9, 17, 25.
  - active_out rises at edge 25.
  - ready_out is first high after edge 32; the first data byte loads at edge 33.
- Data byte 0xBC is transmitted unchanged; the receiver discards it as idle. Sources must not send 0xBC as payload.
- Reset mid-byte: serialization aborts immediately, data_out=0. A pending unaccepted byte is not lost on the source side because it was never acked.
- valid_in toggling between ready cycles: only its value in the ready cycle matters.

Optional Feature:
- PS_TX_PERIODIC_COMMA_EN defined:
  - Counter of consecutive accepted data bytes.
  - When the count reaches COMMA_PERIOD, the next slot is a forced comma: ready_out stays low that slot and the counter clears.
  - Counter also clears on any idle comma slot.
- Undefined: no counter, and every ACTIVE slot is offered.

Decomposition:
- Shared package phy_pkg:
  - COMMA=8'hBC.
  - State typedef {SYNC, ACTIVE}.
  - Byte width constant 8, shared with the receiver.
- Natural sub-module: piso_shift8 (8-bit load/shift register, registered MSB output, load enable).
- Control FSM, sync counter and handshake stay in the top.

Test Plan:
- Reset release, valid_in=0 → data_out shows 10111100 repeated; active_out rises at edge 25; ready_out first high after edge 32.
- After sync, data_in=0xA5 held valid → accepted at first ready; next 8 bits 1,0,1,0,0,1,0,1; then 0xBC while valid_in=0.
- Back-to-back bytes 0x01, 0xFF, 0x80, each presented at its ready cycle → 24 contiguous bits, no gaps or commas between.
- Assert rst_L=0 during bit 3 of 0x5A → data_out=0 and active_out=0 immediately; full 4-comma sync repeats after release.
- Loopback into the receiver at 4f/32f ratio → receiver active after 4 commas; 0x3C, 0xC3 recovered with valid_out_sp; commas not flagged valid.
- With PS_TX_PERIODIC_COMMA_EN, COMMA_PERIOD=2, valid_in always 1 → byte pattern D, D, BC, D, D, BC; ready_out low in each BC slot.

Source files
------------

// File: rtl/phy_pkg.sv
// -----------------------------------------------------------------------------
// phy_pkg
// Definitions shared by the transmit serializer and the serial-to-parallel
// receiver on the same link.
//   BYTE_W     : width of one symbol on the link (8)
//   COMMA      : idle / sync symbol 0xBC
//   tx_state_t : serializer control state {SYNC, ACTIVE}
// -----------------------------------------------------------------------------
package phy_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COMMA = 8'hBC;

  typedef enum logic {
    SYNC,
    ACTIVE
  } tx_state_t;

endpackage

// File: rtl/piso_shift8.sv
// -----------------------------------------------------------------------------
// piso_shift8
// 8-bit parallel-in / serial-out shift register, MSB first, registered output.
// Ports:
//   clk_32f : bit clock, all state on posedge
//   rst_L   : asynchronous active-low reset (clears register and output)
//   load    : take din this edge; din[7] goes straight to dout
//   din     : byte to serialize
//   dout    : registered serial bit
// -----------------------------------------------------------------------------
module piso_shift8
  import phy_pkg::*;
(
  input  logic              clk_32f,
  input  logic              rst_L,
  input  logic              load,
  input  logic [BYTE_W-1:0] din,
  output logic              dout
);

  logic [BYTE_W-1:0] shreg;

  // On a load the MSB is emitted immediately, so the register keeps only the
  // remaining seven bits, pre-shifted to line up with the next MSB position.
  always_ff @(posedge clk_32f or negedge rst_L) begin
    if (!rst_L) begin
      shreg <= '0;
      dout  <= 1'b0;
    end else if (load) begin
      dout  <= din[BYTE_W-1];
      shreg <= {din[BYTE_W-2:0], 1'b0};
    end else begin
      dout  <= shreg[BYTE_W-1];
      shreg <= {shreg[BYTE_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/paralelo_serial_tx.sv
// -----------------------------------------------------------------------------
// paralelo_serial_tx
// Transmit-side serializer. Bytes arrive over valid/ready and leave MSB first,
// one bit per clk_32f. After reset a burst of SYNC_COMMAS commas (0xBC) is sent
// so the far-end receiver can lock; afterwards every 8-cycle slot carries the
// offered byte, or a comma when nothing is offered.
// Parameters:
//   SYNC_COMMAS  : commas sent after reset before data is accepted (>= 1)
//   COMMA_PERIOD : accepted bytes between forced commas (periodic mode only)
// Ports:
//   clk_32f    : bit clock
//   rst_L      : asynchronous active-low reset
//   data_in    : byte to transmit
//   valid_in   : data_in valid, held until accepted
//   ready_out  : slot open; transfer on posedge with valid_in && ready_out
//   data_out   : registered serial bit
//   active_out : sync burst done, data slots available
// Build option:
//   PS_TX_PERIODIC_COMMA_EN : after COMMA_PERIOD consecutive accepted bytes the
//                             next slot is forced to a comma (ready_out low).
// -----------------------------------------------------------------------------
module paralelo_serial_tx
  import phy_pkg::*;
#(
  parameter int SYNC_COMMAS  = 4,
  parameter int COMMA_PERIOD = 16
) (
  input  logic              clk_32f,
  input  logic              rst_L,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              data_out,
  output logic              active_out
);

  localparam int SYNC_W = (SYNC_COMMAS > 1) ? $clog2(SYNC_COMMAS) : 1;

  tx_state_t         state;
  logic [2:0]        bit_cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic              load;
  logic              accept;
  logic              force_comma;
  logic [BYTE_W-1:0] next_byte;

  // A slot boundary is the edge after the last bit of the previous byte.
  assign load = (bit_cnt == 3'd7);

  // ready_out is only ever high on a load cycle in ACTIVE, so it alone
  // qualifies the handshake.
  assign accept    = ready_out && valid_in;
  assign next_byte = accept ? data_in : COMMA;

`ifdef PS_TX_PERIODIC_COMMA_EN
  localparam int PERIOD_W = $clog2(COMMA_PERIOD + 1);

  logic [PERIOD_W-1:0] data_cnt;

  assign force_comma = (data_cnt == PERIOD_W'(COMMA_PERIOD));

  // Run length of back-to-back accepted bytes; any comma slot (idle or
  // forced) breaks the run.
  always_ff @(posedge clk_32f or negedge rst_L) begin
    if (!rst_L) begin
      data_cnt <= '0;
    end else if (load && (state == ACTIVE)) begin
      data_cnt <= accept ? data_cnt + 1'b1 : '0;
    end
  end
`else
  logic unused_cfg;

  assign force_comma = 1'b0;
  assign unused_cfg  = (COMMA_PERIOD == 0);
`endif

  // Slot counter, sync burst and handshake. ready_out is registered: it is
  // raised on the edge that moves bit_cnt to 7, so it is valid for exactly the
  // cycle preceding the load edge of an offered slot.
  always_ff @(posedge clk_32f or negedge rst_L) begin
    if (!rst_L) begin
      state      <= SYNC;
      bit_cnt    <= 3'd7;
      sync_cnt   <= '0;
      ready_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      bit_cnt   <= load ? 3'd0 : bit_cnt + 3'd1;
      ready_out <= (state == ACTIVE) && (bit_cnt == 3'd6) && !force_comma;
      if (load && (state == SYNC)) begin
        if (sync_cnt == SYNC_W'(SYNC_COMMAS - 1)) begin
          state      <= ACTIVE;
          active_out <= 1'b1;
        end else begin
          sync_cnt <= sync_cnt + 1'b1;
        end
      end
    end
  end

  piso_shift8 u_shift (
    .clk_32f (clk_32f),
    .rst_L   (rst_L),
    .load    (load),
    .din     (next_byte),
    .dout    (data_out)
  );

endmodule
